// File: rtl/fifo_rd_pkg.sv
// Shared types and elaboration checks for the FIFO read-side drain controller.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ZERO = 2'd3
    } state_e;

    // The skid buffer must absorb every read still in the pipe plus the word on display.
    function automatic bit skid_depth_ok(input int skid_depth, input int rd_lat);
        return (skid_depth >= (rd_lat + 1));
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus the outgoing valid/ready stream of the drain controller.
interface fifo_rd_drain_if #(
    parameter int WIDTH = 32
);
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [WIDTH-1:0] fifo_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        input  fifo_rempty, fifo_rdata, out_ready,
        output fifo_rinc, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_rempty, fifo_rdata, out_ready,
        input  fifo_rinc, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_rd_drain_chk.sv
// Runtime checks on the drain controller's skid buffer.
module fifo_rd_drain_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full
);
    a_no_skid_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));
endmodule

// File: rtl/sync_skid_fifo.sv
// Small single-clock register FIFO; absorbs words returning from the read pipe.
module sync_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : (ptr + PTR_W'(1));
    endfunction

    // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));

    // Storage array and wrap-around pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
        end
    end

    // Occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: pulls len words out of the async FIFO and re-emits them
// as a valid/ready packet with an end-of-packet marker.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_rd_drain_if.master  bus,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done
);
    localparam int SKID_CW = $clog2(SKID_DEPTH + 1);
    localparam int IFL_W   = $clog2(RD_LAT + 1);

    if (!skid_depth_ok(SKID_DEPTH, RD_LAT)) begin : g_bad_skid_depth
        $error("fifo_rd_drain: SKID_DEPTH must be at least RD_LAT+1");
    end

    state_e             state_r;
    state_e             state_s;
    logic [LEN_W-1:0]   len_q_r;
    logic [LEN_W-1:0]   issue_cnt_r;
    logic [LEN_W-1:0]   emit_cnt_r;
    logic [RD_LAT-1:0]  pipe_r;
    logic [IFL_W-1:0]   inflight_cnt_r;
    logic [SKID_CW-1:0] skid_cnt_s;
    logic               skid_empty_s;
    logic               skid_full_s;
    logic               tap_s;
    logic               handshake_s;
    logic               is_last_s;
    logic               credit_ok_s;

    assign tap_s       = pipe_r[RD_LAT-1];
    assign handshake_s = bus.out_valid && bus.out_ready;
    assign is_last_s   = (emit_cnt_r == (len_q_r - LEN_W'(1)));
    assign credit_ok_s = (int'(skid_cnt_s) + int'(inflight_cnt_r)) < SKID_DEPTH;

    assign bus.fifo_rinc = (state_r == RUN) && !bus.fifo_rempty &&
                           (issue_cnt_r < len_q_r) && credit_ok_s;
    assign bus.out_valid = !skid_empty_s;
    assign bus.out_last  = bus.out_valid && is_last_s;
    assign busy          = (state_r == RUN);
    assign done          = (state_r == DONE) || (state_r == ZERO);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_s = RUN;
                    end else begin
                        state_s = ZERO;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (handshake_s && is_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            ZERO:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Packet length capture and issue/emit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q_r     <= '0;
            issue_cnt_r <= '0;
            emit_cnt_r  <= '0;
        end else if ((state_r == IDLE) && start) begin
            len_q_r     <= len;
            issue_cnt_r <= '0;
            emit_cnt_r  <= '0;
        end else begin
            if (bus.fifo_rinc) begin
                issue_cnt_r <= issue_cnt_r + LEN_W'(1);
            end
            if (handshake_s) begin
                emit_cnt_r <= emit_cnt_r + LEN_W'(1);
            end
        end
    end

    // Read-latency pipe: the tap bit marks the cycle fifo_rdata holds a requested word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_r         <= '0;
            inflight_cnt_r <= '0;
        end else begin
            pipe_r[0] <= bus.fifo_rinc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            case ({bus.fifo_rinc, tap_s})
                2'b10:   inflight_cnt_r <= inflight_cnt_r + IFL_W'(1);
                2'b01:   inflight_cnt_r <= inflight_cnt_r - IFL_W'(1);
                default: inflight_cnt_r <= inflight_cnt_r;
            endcase
        end
    end

    sync_skid_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tap_s),
        .push_data (bus.fifo_rdata),
        .pop       (handshake_s),
        .head_data (bus.out_data),
        .count     (skid_cnt_s),
        .empty     (skid_empty_s),
        .full      (skid_full_s)
    );

    fifo_rd_drain_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tap_s),
        .pop   (handshake_s),
        .full  (skid_full_s)
    );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Scoreboard bench for fifo_rd_drain with a behavioural read-latency FIFO model.
module tb_fifo_rd_drain;
    localparam int WIDTH      = 32;
    localparam int RD_LAT     = 2;
    localparam int SKID_DEPTH = 4;
    localparam int LEN_W      = 16;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic             busy;
    logic             done;

    fifo_rd_drain_if #(.WIDTH(WIDTH)) bus_if ();

    fifo_rd_drain #(
        .WIDTH      (WIDTH),
        .RD_LAT     (RD_LAT),
        .SKID_DEPTH (SKID_DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: 256 words, data appears RD_LAT=2 cycles after an accepted read
    logic [WIDTH-1:0] mem [256];
    int unsigned      wptr = 0;
    int unsigned      rptr = 0;
    logic             flush_req = 1'b0;
    logic [WIDTH-1:0] rd_d1 = '0;
    logic [WIDTH-1:0] rd_d2 = '0;

    assign bus_if.fifo_rempty = (rptr == wptr);
    assign bus_if.fifo_rdata  = rd_d2;

    always @(posedge clk) begin
        rd_d1 <= mem[rptr % 256];
        rd_d2 <= rd_d1;
        if (flush_req) rptr <= wptr;
        else if (bus_if.fifo_rinc && !bus_if.fifo_rempty) rptr <= rptr + 1;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    int   acc_cnt, hs_cnt, done_cnt;
    int   first_acc, last_acc, first_hs, last_hs, done_cyc;
    logic busy_seen, valid_seen;
    logic clr_req   = 1'b0;
    logic chk_outst = 1'b0;
    int   start_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic fifo_write(input logic [WIDTH-1:0] d);
        mem[wptr % 256] = d;
        wptr = wptr + 1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int l);
        start     = 1'b1;
        len       = LEN_W'(l);
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) tick();
        check("done_timeout", 64'(done_cnt > base), 64'd1);
    endtask

    // Monitor: counts reads, handshakes and done pulses, and drains the scoreboard
    initial begin
        logic             prev_stall;
        logic [WIDTH-1:0] prev_data;
        exp_t             e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (clr_req) begin
                acc_cnt = 0; hs_cnt = 0; done_cnt = 0;
                first_acc = -1; last_acc = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
                busy_seen = 1'b0; valid_seen = 1'b0;
            end
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (bus_if.fifo_rinc) begin
                    check("rinc_while_empty", 64'(bus_if.fifo_rempty), 64'd0);
                    acc_cnt++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(bus_if.out_valid), 64'd1);
                    check("stall_data", 64'(bus_if.out_data), 64'(prev_data));
                end
                if (bus_if.out_valid) valid_seen = 1'b1;
                if (busy) busy_seen = 1'b1;
                if (bus_if.out_valid && bus_if.out_ready) begin
                    check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(bus_if.out_data), 64'(e.data));
                        check("out_last", 64'(bus_if.out_last), 64'(e.last));
                    end
                    hs_cnt++;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
                if (chk_outst) check("outstanding_le_skid", 64'((acc_cnt - hs_cnt) <= SKID_DEPTH), 64'd1);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_in_done", 64'(busy), 64'd0);
                end
                prev_stall = bus_if.out_valid && !bus_if.out_ready;
                prev_data  = bus_if.out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        // reset values
        check("rst_rinc", 64'(bus_if.fifo_rinc), 64'd0);
        check("rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_data", 64'(bus_if.out_data), 64'd0);
        check("rst_last", 64'(bus_if.out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        // full-rate packet of 8
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            fifo_write(WIDTH'(32'h100 + i));
            push_exp(WIDTH'(32'h100 + i), (i == 7));
        end
        pulse_start(8);
        wait_done(100);
        tick();
        check("t8_accepts", 64'(acc_cnt), 64'd8);
        check("t8_first_rinc", 64'(first_acc - start_cyc), 64'd1);
        check("t8_rinc_back2back", 64'(last_acc - first_acc), 64'd7);
        check("t8_first_latency", 64'(first_hs - first_acc), 64'(RD_LAT + 1));
        check("t8_emit_back2back", 64'(last_hs - first_hs), 64'd7);
        check("t8_done_after_last", 64'(done_cyc - last_hs), 64'd1);
        check("t8_done_count", 64'(done_cnt), 64'd1);
        check("t8_busy_seen", 64'(busy_seen), 64'd1);
        check("t8_sb_empty", 64'(exp_q.size()), 64'd0);

        // len=0 with words already waiting in the FIFO
        for (int i = 0; i < 3; i++) fifo_write(WIDTH'(32'h200 + i));
        clear_stats();
        pulse_start(0);
        for (int i = 0; i < 6; i++) tick();
        check("z_done_count", 64'(done_cnt), 64'd1);
        check("z_done_cycle", 64'(done_cyc - start_cyc), 64'd1);
        check("z_no_rinc", 64'(acc_cnt), 64'd0);
        check("z_busy_low", 64'(busy_seen), 64'd0);
        check("z_valid_low", 64'(valid_seen), 64'd0);

        // underflow stall: 3 words present, 2 more arrive 20 cycles later
        clear_stats();
        for (int i = 0; i < 5; i++) push_exp(WIDTH'(32'h200 + i), (i == 4));
        pulse_start(5);
        for (int i = 0; i < 20; i++) tick();
        snap = acc_cnt;
        check("u_accepts_stalled", 64'(snap), 64'd3);
        fifo_write(WIDTH'(32'h203));
        fifo_write(WIDTH'(32'h204));
        wait_done(100);
        tick();
        check("u_accepts", 64'(acc_cnt), 64'd5);
        check("u_done_count", 64'(done_cnt), 64'd1);
        check("u_sb_empty", 64'(exp_q.size()), 64'd0);

        // backpressure: out_ready low for 10 cycles during a len=16 packet
        clear_stats();
        for (int i = 0; i < 16; i++) begin
            fifo_write(WIDTH'(32'h300 + i));
            push_exp(WIDTH'(32'h300 + i), (i == 15));
        end
        chk_outst = 1'b1;
        pulse_start(16);
        for (int i = 0; i < 4; i++) tick();
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("bp_outstanding_full", 64'(acc_cnt - hs_cnt), 64'(SKID_DEPTH));
        bus_if.out_ready = 1'b1;
        wait_done(200);
        tick();
        chk_outst = 1'b0;
        check("bp_accepts", 64'(acc_cnt), 64'd16);
        check("bp_emits", 64'(hs_cnt), 64'd16);
        check("bp_done_count", 64'(done_cnt), 64'd1);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // second start while busy is ignored
        clear_stats();
        for (int i = 0; i < 6; i++) begin
            fifo_write(WIDTH'(32'h400 + i));
            push_exp(WIDTH'(32'h400 + i), (i == 5));
        end
        for (int i = 0; i < 3; i++) fifo_write(WIDTH'(32'h4F0 + i));
        pulse_start(6);
        tick();
        tick();
        pulse_start(3);
        wait_done(100);
        for (int i = 0; i < 10; i++) tick();
        check("ig_accepts", 64'(acc_cnt), 64'd6);
        check("ig_emits", 64'(hs_cnt), 64'd6);
        check("ig_done_count", 64'(done_cnt), 64'd1);
        check("ig_sb_empty", 64'(exp_q.size()), 64'd0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;

        // asynchronous reset after two emitted words, then a fresh len=2 packet
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            fifo_write(WIDTH'(32'h500 + i));
            push_exp(WIDTH'(32'h500 + i), (i == 7));
        end
        pulse_start(8);
        for (int i = 0; i < 100 && hs_cnt < 2; i++) tick();
        check("mr_two_words_timeout", 64'(hs_cnt), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_rinc", 64'(bus_if.fifo_rinc), 64'd0);
        check("mr_valid", 64'(bus_if.out_valid), 64'd0);
        check("mr_data", 64'(bus_if.out_data), 64'd0);
        check("mr_last", 64'(bus_if.out_last), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_done", 64'(done), 64'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        push_exp(mem[rptr % 256], 1'b0);
        push_exp(mem[(rptr + 1) % 256], 1'b1);
        pulse_start(2);
        wait_done(100);
        tick();
        check("mr_accepts", 64'(acc_cnt), 64'd2);
        check("mr_emits", 64'(hs_cnt), 64'd2);
        check("mr_done_count", 64'(done_cnt), 64'd1);
        check("mr_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
